// File: rtl/iq_dsp_pkg.sv
// Shared DSP definitions: sample type, default halfband coefficients and
// the round-half-up / saturate helper reused by later DSP stages.
// No logic of its own; consumers decide pipelining and flow control.
package iq_dsp_pkg;

  // Default sample and coefficient widths
  localparam int SAMPLE_W = 12;
  localparam int COEF_W   = 12;

  // Default 7-tap halfband: h0=h6=HB_C0, h2=h4=HB_C1, h3=HB_CC, h1=h5=0.
  // 2*HB_C0 + 2*HB_C1 + HB_CC = 1024 = 2^HB_SHIFT, so DC gain is exactly one.
  localparam int HB_C0    = -32;
  localparam int HB_C1    = 288;
  localparam int HB_CC    = 512;
  localparam int HB_SHIFT = 10;

  // Working width of the round/saturate helper; any accumulator up to this
  // width is sign-extended into it by the caller.
  localparam int RS_W = 40;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Round half up (add half an LSB, arithmetic shift = floor), then clamp to
  // the signed range of a bw-bit result. The caller keeps the low bw bits.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     shift,
    input int                     bw
  );
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    half = (shift > 0) ? (RS_W'(1) <<< (shift - 1)) : RS_W'(0);
    r    = (acc + half) >>> shift;
    hi   = (RS_W'(1) <<< (bw - 1)) - RS_W'(1);
    lo   = -(RS_W'(1) <<< (bw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/hb7_mac.sv
// One channel of the 7-tap halfband: delay line, pre-add/multiply register, round/saturate.
// y is valid combinationally one cycle after mac_en, i.e. two edges after the shift.
// No backpressure: shift_en and mac_en are obeyed unconditionally; clr wipes all state.
module hb7_mac
  import iq_dsp_pkg::*;
#(
  parameter int BW    = SAMPLE_W,
  parameter int CBW   = COEF_W,
  parameter int C0    = HB_C0,
  parameter int C1    = HB_C1,
  parameter int CC    = HB_CC,
  parameter int SHIFT = HB_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 mac_en,
  input  logic signed [BW-1:0] x_in,
  output logic signed [BW-1:0] y
);

  // Product width: (BW+1)-bit pre-add times CBW-bit coefficient.
  // Three products summed need two more bits to stay exact.
  localparam int PW = BW + 1 + CBW;
  localparam int AW = PW + 2;

  localparam logic signed [CBW-1:0] K_OUTER  = CBW'(C0);
  localparam logic signed [CBW-1:0] K_INNER  = CBW'(C1);
  localparam logic signed [CBW-1:0] K_CENTRE = CBW'(CC);

  // dl[0] is the newest sample, dl[6] the oldest
  logic signed [BW-1:0] dl [7];
  logic signed [BW:0]   pa_outer;
  logic signed [BW:0]   pa_inner;
  logic signed [PW-1:0] p_outer;
  logic signed [PW-1:0] p_inner;
  logic signed [PW-1:0] p_centre;
  logic signed [AW-1:0] acc;

  // Delay line: shift one place per accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) dl[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < 7; k++) dl[k] <= '0;
    end else if (shift_en) begin
      dl[0] <= x_in;
      for (int k = 1; k < 7; k++) dl[k] <= dl[k-1];
    end
  end

  // Symmetric pre-adds, one bit wider than a sample so they cannot wrap
  always_comb begin
    pa_outer = (BW+1)'(dl[0]) + (BW+1)'(dl[6]);
    pa_inner = (BW+1)'(dl[2]) + (BW+1)'(dl[4]);
  end

  // Product register: captures the three tap products of a triggering line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_outer  <= '0;
      p_inner  <= '0;
      p_centre <= '0;
    end else if (clr) begin
      p_outer  <= '0;
      p_inner  <= '0;
      p_centre <= '0;
    end else if (mac_en) begin
      p_outer  <= PW'(pa_outer) * PW'(K_OUTER);
      p_inner  <= PW'(pa_inner) * PW'(K_INNER);
      p_centre <= PW'(dl[3])    * PW'(K_CENTRE);
    end
  end

  // Full-precision sum, then round half up and saturate to BW bits
  always_comb begin
    acc = AW'(p_outer) + AW'(p_inner) + AW'(p_centre);
    y   = BW'(round_sat(RS_W'(acc), SHIFT, BW));
  end

endmodule

// File: rtl/iq_hb_decim2.sv
// I/Q halfband decimate-by-2: filters both channels and keeps every second result.
// Result enters the output buffer two edges after the triggering sample; out_valid the cycle after.
// Input cannot be stalled; 2-entry valid/ready buffer drops new results when full and sets sticky ovf.
module iq_hb_decim2
  import iq_dsp_pkg::*;
#(
  parameter int BW    = SAMPLE_W,
  parameter int CBW   = COEF_W,
  parameter int C0    = HB_C0,
  parameter int C1    = HB_C1,
  parameter int CC    = HB_CC,
  parameter int SHIFT = HB_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [BW-1:0] in_i,
  input  logic signed [BW-1:0] in_q,
  input  logic                 sync,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [BW-1:0] out_i,
  output logic signed [BW-1:0] out_q,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  // Decimation phase and pipeline valids
  logic phase;
  logic stg0_vld;   // delay line holds a line to be filtered
  logic stg1_vld;   // product register holds that line's products
  logic accept;
  logic trig;

  // Filter results, combinational from the product registers
  logic signed [BW-1:0] y_i;
  logic signed [BW-1:0] y_q;

  // Output buffer: two slots addressed by a read pointer and occupancy
  logic signed [BW-1:0] buf_i [2];
  logic signed [BW-1:0] buf_q [2];
  logic                 rd_ptr;
  logic [1:0]           cnt;
  logic                 wr_ptr;
  logic                 full;
  logic                 pop;
  logic                 wr_req;
  logic                 do_wr;
  logic                 drop;

  // A sample in the same cycle as sync is discarded
  assign accept = in_valid & ~sync;
  // Every second accepted sample produces an output
  assign trig   = accept & phase;

  hb7_mac #(
    .BW(BW), .CBW(CBW), .C0(C0), .C1(C1), .CC(CC), .SHIFT(SHIFT)
  ) u_mac_i (
    .clk      (clk),
    .rst      (rst),
    .clr      (sync),
    .shift_en (accept),
    .mac_en   (stg0_vld),
    .x_in     (in_i),
    .y        (y_i)
  );

  hb7_mac #(
    .BW(BW), .CBW(CBW), .C0(C0), .C1(C1), .CC(CC), .SHIFT(SHIFT)
  ) u_mac_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (sync),
    .shift_en (accept),
    .mac_en   (stg0_vld),
    .x_in     (in_q),
    .y        (y_q)
  );

  // Phase toggles per accepted sample; valids follow the trigger down the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 1'b0;
      stg0_vld <= 1'b0;
      stg1_vld <= 1'b0;
    end else if (sync) begin
      phase    <= 1'b0;
      stg0_vld <= 1'b0;
      stg1_vld <= 1'b0;
    end else begin
      if (accept) phase <= ~phase;
      stg0_vld <= trig;
      stg1_vld <= stg0_vld;
    end
  end

  // Buffer control: a pop frees a slot for a write on the same edge, so a
  // full buffer only drops when nothing is being taken out.
  always_comb begin
    full   = (cnt == 2'd2);
    pop    = out_valid & out_ready;
    wr_req = stg1_vld & ~sync;
    do_wr  = wr_req & (~full | pop);
    drop   = wr_req & full & ~pop;
    // Next free slot; when full it is the head slot being popped this edge
    wr_ptr = rd_ptr ^ cnt[0];
  end

  // Output buffer storage, read pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      buf_i[0] <= '0;
      buf_i[1] <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (sync) begin
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      buf_i[0] <= '0;
      buf_i[1] <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (do_wr) begin
        buf_i[wr_ptr] <= y_i;
        buf_q[wr_ptr] <= y_q;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_wr} - {1'b0, pop};
    end
  end

  // Sticky overflow: a drop wins over a same-edge clear; sync leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign out_valid = (cnt != 2'd0);
  assign out_i     = buf_i[rd_ptr];
  assign out_q     = buf_q[rd_ptr];

endmodule

// File: tb/tb_iq_hb_decim2.sv
module tb_iq_hb_decim2;
  import iq_dsp_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid;
  sample_t in_i;
  sample_t in_q;
  logic    sync;
  logic    out_valid;
  logic    out_ready;
  sample_t out_i;
  sample_t out_q;
  logic    ovf;
  logic    clr_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iq_hb_decim2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .sync      (sync),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  // ---------------- reference model ----------------
  typedef int line_t[7];
  line_t mxi;
  line_t mxq;
  bit    m_ph;
  int    m_edge;
  bit    m_ovf;
  int    pend_t[$];
  int    pend_i[$];
  int    pend_q[$];
  int    mbuf_i[$];
  int    mbuf_q[$];
  int    pop_i[$];
  int    pop_q[$];

  // Halfband straight from the filter equation, integer arithmetic
  function automatic int hb_ref(input line_t x);
    int acc;
    int y;
    acc = -32 * (x[0] + x[6]) + 288 * (x[2] + x[4]) + 512 * x[3];
    y   = (acc + 512) >>> 10;
    if (y > 2047)  y = 2047;
    if (y < -2048) y = -2048;
    return y;
  endfunction

  task automatic model_clear(input bit keep_ovf);
    for (int k = 0; k < 7; k++) begin
      mxi[k] = 0;
      mxq[k] = 0;
    end
    m_ph = 1'b0;
    pend_t.delete(); pend_i.delete(); pend_q.delete();
    mbuf_i.delete(); mbuf_q.delete();
    if (!keep_ovf) m_ovf = 1'b0;
  endtask

  // One clock edge of the model using the currently driven inputs
  task automatic model_edge();
    bit pop;
    bit drop;
    m_edge++;
    if (sync) begin
      model_clear(1'b1);
      if (clr_ovf) m_ovf = 1'b0;
      return;
    end
    pop  = (mbuf_i.size() > 0) && out_ready;
    drop = 1'b0;
    if (pop) begin
      void'(mbuf_i.pop_front());
      void'(mbuf_q.pop_front());
    end
    if (pend_t.size() > 0 && pend_t[0] == m_edge) begin
      if (mbuf_i.size() < 2) begin
        mbuf_i.push_back(pend_i[0]);
        mbuf_q.push_back(pend_q[0]);
      end else begin
        drop = 1'b1;
      end
      void'(pend_t.pop_front());
      void'(pend_i.pop_front());
      void'(pend_q.pop_front());
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (in_valid) begin
      for (int k = 6; k > 0; k--) begin
        mxi[k] = mxi[k-1];
        mxq[k] = mxq[k-1];
      end
      mxi[0] = int'(in_i);
      mxq[0] = int'(in_q);
      if (m_ph) begin
        pend_t.push_back(m_edge + 2);
        pend_i.push_back(hb_ref(mxi));
        pend_q.push_back(hb_ref(mxq));
      end
      m_ph = ~m_ph;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(out_valid), (mbuf_i.size() > 0) ? 1 : 0);
    chk("ovf", int'(ovf), int'(m_ovf));
    if (mbuf_i.size() > 0) begin
      chk("out_i", int'(out_i), mbuf_i[0]);
      chk("out_q", int'(out_q), mbuf_q[0]);
    end
  endtask

  // Drive one cycle, record what the consumer takes, advance model and DUT
  task automatic cyc(input bit v, input int i, input int q, input bit rdy,
                     input bit syn, input bit clr);
    in_valid  = v;
    in_i      = 12'(i);
    in_q      = 12'(q);
    out_ready = rdy;
    sync      = syn;
    clr_ovf   = clr;
    if (out_valid && out_ready && !sync) begin
      pop_i.push_back(int'(out_i));
      pop_q.push_back(int'(out_q));
    end
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic int rnd_s();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 2047;
    if (r == 1) return -2048;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // ---------------- vector table ----------------
  typedef logic [6:0][11:0] tline_t;
  typedef struct packed {
    tline_t xi;
    tline_t xq;
    int     ei;
    int     eq;
  } vec_t;

  function automatic tline_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6);
    tline_t r;
    r[0] = 12'(a0); r[1] = 12'(a1); r[2] = 12'(a2); r[3] = 12'(a3);
    r[4] = 12'(a4); r[5] = 12'(a5); r[6] = 12'(a6);
    return r;
  endfunction

  vec_t tv[5];

  initial begin
    int imp_exp[6];
    int b0;
    int b1;

    rst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    sync = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    m_edge = 0;
    model_clear(1'b0);

    // Delay-line contents at the trigger (x0..x6) and expected result
    tv[0] = '{xi: mk(-2048, 0, 2047, 2047, 2047, 0, -2048),
              xq: mk(2047, 0, -2048, -2048, -2048, 0, 2047), ei: 2047, eq: -2048};
    tv[1] = '{xi: mk(1000, 1000, 1000, 1000, 1000, 1000, 1000),
              xq: mk(-1000, -1000, -1000, -1000, -1000, -1000, -1000), ei: 1000, eq: -1000};
    tv[2] = '{xi: mk(0, 0, 0, 1, 0, 0, 0), xq: mk(0, 0, 0, -1, 0, 0, 0), ei: 1, eq: 0};
    tv[3] = '{xi: mk(0, 0, 0, 3, 0, 0, 0), xq: mk(17, 0, 0, 0, 0, 0, 0), ei: 2, eq: -1};
    tv[4] = '{xi: mk(0, 0, 100, 0, 100, 0, 0), xq: mk(0, 2047, 0, 0, 0, 2047, 0), ei: 56, eq: 0};
    imp_exp = '{-32, 288, 288, -32, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    // Table: load a full line, the 4th output after sync is the line under test
    for (int t = 0; t < 5; t++) begin
      cyc(0, 0, 0, 1, 1, 0);
      pop_i.delete(); pop_q.delete();
      for (int s = 0; s < 8; s++) begin
        if (s == 0) cyc(1, 0, 0, 1, 0, 0);
        else cyc(1, int'($signed(tv[t].xi[7-s])), int'($signed(tv[t].xq[7-s])), 1, 0, 0);
      end
      repeat (4) cyc(0, 0, 0, 1, 0, 0);
      chk("vec_count", pop_i.size(), 4);
      if (pop_i.size() == 4) begin
        chk("vec_i", pop_i[3], tv[t].ei);
        chk("vec_q", pop_q[3], tv[t].eq);
      end
    end

    // Impulse on the 2nd accepted sample walks through the taps
    cyc(0, 0, 0, 1, 1, 0);
    pop_i.delete(); pop_q.delete();
    for (int s = 1; s <= 12; s++) cyc(1, (s == 2) ? 1024 : 0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    chk("imp_count", pop_i.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < pop_i.size()) begin
        chk("imp_i", pop_i[k], imp_exp[k]);
        chk("imp_q", pop_q[k], 0);
      end
    end

    // Backpressure: 8 samples, nothing consumed -> 2 held, later ones dropped
    cyc(0, 0, 0, 1, 1, 1);
    for (int s = 0; s < 8; s++) cyc(1, rnd_s(), rnd_s(), 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("bp_ovf", int'(ovf), 1);
    chk("bp_valid", int'(out_valid), 1);
    b0 = (mbuf_i.size() > 0) ? mbuf_i[0] : 99999;
    b1 = (mbuf_i.size() > 1) ? mbuf_i[1] : 99999;
    pop_i.delete(); pop_q.delete();
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    chk("bp_pops", pop_i.size(), 2);
    if (pop_i.size() == 2) begin
      chk("bp_first", pop_i[0], b0);
      chk("bp_second", pop_i[1], b1);
    end
    chk("bp_empty", int'(out_valid), 0);
    cyc(0, 0, 0, 1, 0, 1);
    chk("bp_clr_ovf", int'(ovf), 0);

    // Full buffer with a write and a pop on the same edge
    cyc(0, 0, 0, 1, 1, 0);
    for (int s = 0; s < 6; s++) cyc(1, rnd_s(), rnd_s(), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    pop_i.delete(); pop_q.delete();
    cyc(0, 0, 0, 1, 0, 0);
    chk("fp_ovf", int'(ovf), 0);
    chk("fp_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fp_pops", pop_i.size(), 3);
    chk("fp_empty", int'(out_valid), 0);

    // sync with in_valid mid-stream
    cyc(0, 0, 0, 1, 1, 0);
    for (int s = 0; s < 4; s++) cyc(1, rnd_s(), rnd_s(), 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    chk("sy_full", int'(out_valid), 1);
    cyc(1, 500, 500, 0, 1, 0);
    chk("sy_empty", int'(out_valid), 0);
    cyc(1, 100, -100, 0, 0, 0);
    cyc(1, 200, -200, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sy_not_yet", int'(out_valid), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sy_second", int'(out_valid), 1);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 3) != 0, rnd_s(), rnd_s(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset mid-stream
    for (int s = 0; s < 10; s++) cyc(1, rnd_s(), rnd_s(), 0, 0, 0);
    chk("ar_pre_ovf", int'(ovf), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_ovf", int'(ovf), 0);
    chk("ar_out_i", int'(out_i), 0);
    model_clear(1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) cyc(1, rnd_s(), rnd_s(), $urandom_range(0, 1) != 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
